// File: rtl/cache_ctrl.sv
// Sequencing FSM for a direct-mapped write-back data cache: hit service, dirty writeback, refill, timeout.
// Optional statistics counters are built in when CACHE_STATS_EN is defined.
module cache_ctrl #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic             cpu_is_word,
    output logic             cpu_ready,
    output logic             err,
    input  logic             cache_hit,
    input  logic             cache_valid,
    input  logic             cache_dirty,
    output logic             we_cache,
    output logic             is_word,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             data_sel,
    output logic             mem_re,
    output logic             mem_we,
    output logic             addr_sel,
    input  logic             mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] wb_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  wait_cnt_r;
    logic        cnt_clr_s;
    logic        cnt_inc_s;
    logic        timeout_s;

    assign timeout_s = (wait_cnt_r >= MAX_WAIT_C);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory wait counter: restarts on every state change, saturates rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_r <= 8'd0;
        end else if (cnt_clr_s) begin
            wait_cnt_r <= 8'd0;
        end else if (cnt_inc_s && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Next-state and strobe decode; array valid/dirty bits are held unless a state overrides them
    always_comb begin
        next_state_s = state_r;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        cpu_ready    = 1'b0;
        err          = 1'b0;
        we_cache     = 1'b0;
        is_word      = 1'b0;
        set_valid    = cache_valid;
        set_dirty    = cache_dirty;
        data_sel     = 1'b0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    if (cache_hit) begin
                        cpu_ready = 1'b1;
                        if (cpu_we) begin
                            we_cache  = 1'b1;
                            is_word   = cpu_is_word;
                            data_sel  = 1'b0;
                            set_valid = 1'b1;
                            set_dirty = 1'b1;
                        end else begin
                            we_cache = 1'b0;
                        end
                    end else begin
                        cnt_clr_s = 1'b1;
                        if (cache_valid && cache_dirty) begin
                            next_state_s = WRITEBACK;
                        end else begin
                            next_state_s = REFILL;
                        end
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (timeout_s) begin
                    err          = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                    if (mem_ack) begin
                        set_dirty    = 1'b0;
                        cnt_clr_s    = 1'b1;
                        next_state_s = REFILL;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            REFILL: begin
                if (timeout_s) begin
                    err          = 1'b1;
                    cnt_clr_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    mem_re   = 1'b1;
                    addr_sel = 1'b0;
                    if (mem_ack) begin
                        we_cache     = 1'b1;
                        is_word      = 1'b1;
                        data_sel     = 1'b1;
                        set_valid    = 1'b1;
                        set_dirty    = 1'b0;
                        cnt_clr_s    = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clr_s    = 1'b1;
                next_state_s = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic miss_pend_r;
    logic miss_evt_s;
    logic hit_evt_s;
    logic wb_evt_s;

    assign miss_evt_s = (state_r == IDLE) && cpu_req && !cache_hit;
    assign hit_evt_s  = cpu_ready && !miss_pend_r;
    assign wb_evt_s   = (state_r == WRITEBACK) && mem_ack && !timeout_s;

    // Remembers that the request in flight missed, so its final hit cycle is not counted as a hit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_pend_r <= 1'b0;
        end else if (miss_evt_s) begin
            miss_pend_r <= 1'b1;
        end else if (cpu_ready || ((state_r == IDLE) && !cpu_req)) begin
            miss_pend_r <= 1'b0;
        end else begin
            miss_pend_r <= miss_pend_r;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (hit_evt_s && (hit_cnt != {CNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
                hit_cnt <= hit_cnt;
            end
            if (miss_evt_s && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end else begin
                miss_cnt <= miss_cnt;
            end
            if (wb_evt_s && (wb_cnt != {CNT_W{1'b1}})) begin
                wb_cnt <= wb_cnt + CNT_W'(1);
            end else begin
                wb_cnt <= wb_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed self-checking bench for cache_ctrl (MAX_WAIT=4); checks statistics when CACHE_STATS_EN is defined.
module tb_cache_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_is_word = 1'b0;
    logic cache_hit = 1'b0, cache_valid = 1'b0, cache_dirty = 1'b0, mem_ack = 1'b0;
    logic cpu_ready, err, we_cache, is_word, set_valid, set_dirty, data_sel, mem_re, mem_we, addr_sel;
`ifdef CACHE_STATS_EN
    logic [CNT_W-1:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // {ready, err, we_cache, is_word, set_valid, set_dirty, data_sel, mem_re, mem_we, addr_sel}
    logic [9:0] outs;
    assign outs = {cpu_ready, err, we_cache, is_word, set_valid, set_dirty, data_sel, mem_re, mem_we, addr_sel};

    cache_ctrl #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_is_word(cpu_is_word),
        .cpu_ready(cpu_ready), .err(err), .cache_hit(cache_hit), .cache_valid(cache_valid),
        .cache_dirty(cache_dirty), .we_cache(we_cache), .is_word(is_word), .set_valid(set_valid),
        .set_dirty(set_dirty), .data_sel(data_sel), .mem_re(mem_re), .mem_we(mem_we),
        .addr_sel(addr_sel), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic wd,
                         input logic hit, input logic v, input logic d, input logic ack);
        cpu_req = req; cpu_we = we; cpu_is_word = wd;
        cache_hit = hit; cache_valid = v; cache_dirty = d; mem_ack = ack;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_eq("reset_outs", 32'(outs), 32'h0);
        tick();
        rst = 1'b0;

        // Load hit
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); check_eq("load_hit", 32'(outs), 32'(10'b1000100000));
        tick();

        // Word store hit
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); check_eq("store_hit", 32'(outs), 32'(10'b1011110000));
        tick();

        // Clean load miss, ack on third refill cycle
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); check_eq("clean_miss_idle", 32'(outs), 32'h0);
        tick();
        @(negedge clk); check_eq("refill_wait1", 32'(outs), 32'(10'b0000000100));
        tick();
        @(negedge clk); check_eq("refill_wait2", 32'(outs), 32'(10'b0000000100));
        tick();
        mem_ack = 1'b1;
        @(negedge clk); check_eq("refill_ack", 32'(outs), 32'(10'b0011101100));
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); check_eq("post_refill_hit", 32'(outs), 32'(10'b1000100000));
        tick();

        // Dirty byte-store miss
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); check_eq("dirty_miss_idle", 32'(outs), 32'(10'b0000110000));
        tick();
        @(negedge clk); check_eq("wb_wait", 32'(outs), 32'(10'b0000110011));
        tick();
        mem_ack = 1'b1;
        @(negedge clk); check_eq("wb_ack", 32'(outs), 32'(10'b0000100011));
        tick();
        cache_dirty = 1'b0;
        @(negedge clk); check_eq("byte_refill_ack", 32'(outs), 32'(10'b0011101100));
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk); check_eq("byte_merge_hit", 32'(outs), 32'(10'b1010110000));
        tick();

        // Timeout: no ack for MAX_WAIT refill cycles
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); check_eq("to_idle", 32'(outs), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk); check_eq($sformatf("to_wait%0d", i), 32'(outs), 32'(10'b0000000100));
        end
        tick();
        @(negedge clk); check_eq("to_err", 32'(outs), 32'(10'b0100000000));
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); check_eq("to_back_idle_ack_ignored", 32'(outs), 32'h0);
        tick();
        mem_ack = 1'b0;

`ifdef CACHE_STATS_EN
        check_eq("hit_cnt", hit_cnt, 32'd2);
        check_eq("miss_cnt", miss_cnt, 32'd3);
        check_eq("wb_cnt", wb_cnt, 32'd1);
`endif

        // Asynchronous reset in the middle of a refill
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk); check_eq("rst_pre_refill", 32'(outs), 32'(10'b0000000100));
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_mem_re", 32'(mem_re), 32'h0);
`ifdef CACHE_STATS_EN
        check_eq("rst_hit_cnt", hit_cnt, 32'd0);
        check_eq("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        @(negedge clk); check_eq("post_rst_outs", 32'(outs), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
